// File: rtl/linha_envase_param.sv
// rtl/linha_envase_param.sv - bottling-line filling-station controller
// Stock, run control, fill FSM with timeout, QC handshake and batch counting.
module linha_envase_param #(
  parameter int STOCK_W      = 8,
  parameter int STOCK_MAX    = 99,
  parameter int BATCH        = 12,
  parameter int BATCH_W      = 8,
  parameter int REJ_W        = 8,
  parameter int FILL_TIMEOUT = 50
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start_pulse,
  input  logic                       add_pulse,
  input  logic                       garrafa,
  input  logic                       cheia,
  input  logic                       aprovado,
  input  logic                       reprovado,
  output logic                       running,
  output logic                       motor,
  output logic                       valvula,
  output logic                       descartado,
  output logic [STOCK_W-1:0]         estoque,
  output logic [$clog2(BATCH)-1:0]   lote_parcial,
  output logic [BATCH_W-1:0]         lotes,
  output logic [REJ_W-1:0]           rejeitados,
  output logic                       alarme_estoque,
  output logic                       alarme_timeout
);
  localparam int LP_W  = $clog2(BATCH);
  localparam int TMR_W = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FEED, FILL, CHECK, DISCARD, ADVANCE, FAULT} state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer;
  logic               consume;
  logic               running_n;
  logic [STOCK_W-1:0] estoque_n;

  // Input priority inside FILL: cheia beats bottle loss, which beats the timer.
  always_comb begin
    state_n = state;
    consume = 1'b0;
    case (state)
      IDLE:    if (running && estoque != '0) state_n = FEED;
      FEED:    if (garrafa) begin
                 state_n = FILL;
                 consume = 1'b1;
               end
      FILL:    if (cheia) state_n = CHECK;
               else if (!garrafa || timer == TMR_W'(FILL_TIMEOUT - 1)) state_n = FAULT;
      CHECK:   if (reprovado) state_n = DISCARD;
               else if (aprovado) state_n = ADVANCE;
      DISCARD: state_n = ADVANCE;
      ADVANCE: if (!garrafa) state_n = IDLE;
      FAULT:   if (start_pulse) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A fault kills the run request; the clearing pulse does not re-arm it.
  always_comb begin
    running_n = running;
    if (state == FAULT || state_n == FAULT) running_n = 1'b0;
    else if (start_pulse) running_n = !running;
  end

  always_comb begin
    estoque_n = estoque;
    if (add_pulse && !consume) begin
      if (estoque != STOCK_W'(STOCK_MAX)) estoque_n = estoque + 1'b1;
    end else if (consume && !add_pulse) begin
      estoque_n = estoque - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state          <= IDLE;
      timer          <= '0;
      running        <= 1'b0;
      motor          <= 1'b0;
      valvula        <= 1'b0;
      descartado     <= 1'b0;
      estoque        <= '0;
      lote_parcial   <= '0;
      lotes          <= '0;
      rejeitados     <= '0;
      alarme_estoque <= 1'b0;
      alarme_timeout <= 1'b0;
    end else begin
      state          <= state_n;
      running        <= running_n;
      estoque        <= estoque_n;
      motor          <= (state_n == FEED) || (state_n == ADVANCE);
      valvula        <= (state_n == FILL);
      descartado     <= (state_n == DISCARD);
      alarme_timeout <= (state_n == FAULT);
      alarme_estoque <= (state_n == IDLE) && running_n && (estoque_n == '0);

      if (state == FILL && state_n == FILL) timer <= timer + 1'b1;
      else timer <= '0;

      if (state == CHECK && state_n == DISCARD && rejeitados != '1)
        rejeitados <= rejeitados + 1'b1;

      if (state == CHECK && state_n == ADVANCE) begin
        if (lote_parcial == LP_W'(BATCH - 1)) begin
          lote_parcial <= '0;
          lotes        <= lotes + 1'b1;
        end else begin
          lote_parcial <= lote_parcial + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_linha_envase_param.sv
// tb/tb_linha_envase_param.sv - randomized and directed bench for linha_envase_param
module tb_linha_envase_param;
  localparam int STOCK_MAX    = 99;
  localparam int BATCH        = 12;
  localparam int FILL_TIMEOUT = 50;
  localparam int REJ_MAX      = 255;
  localparam int LOTES_MOD    = 256;

  localparam int P_IDLE = 0, P_FEED = 1, P_FILL = 2, P_CHECK = 3,
                 P_DISC = 4, P_ADV = 5, P_FAULT = 6;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start_pulse = 1'b0, add_pulse = 1'b0, garrafa = 1'b0, cheia = 1'b0;
  logic       aprovado = 1'b0, reprovado = 1'b0;
  logic       running, motor, valvula, descartado, alarme_estoque, alarme_timeout;
  logic [7:0] estoque, lotes, rejeitados;
  logic [3:0] lote_parcial;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 CLK = ~CLK;

  linha_envase_param dut (
    .CLK(CLK), .reset(reset), .start_pulse(start_pulse), .add_pulse(add_pulse),
    .garrafa(garrafa), .cheia(cheia), .aprovado(aprovado), .reprovado(reprovado),
    .running(running), .motor(motor), .valvula(valvula), .descartado(descartado),
    .estoque(estoque), .lote_parcial(lote_parcial), .lotes(lotes),
    .rejeitados(rejeitados), .alarme_estoque(alarme_estoque),
    .alarme_timeout(alarme_timeout)
  );

  // Reference: phase, run flag, stock level, total approvals, rejects, cycles spent filling.
  int m_ph, m_run, m_stock, m_appr, m_rej, m_fill, nph;
  bit take;

  always @(posedge CLK) begin
    if (!reset) begin
      m_ph = P_IDLE; m_run = 0; m_stock = 0; m_appr = 0; m_rej = 0; m_fill = 0;
    end else begin
      nph  = m_ph;
      take = 1'b0;
      case (m_ph)
        P_IDLE:  if (m_run != 0 && m_stock > 0) nph = P_FEED;
        P_FEED:  if (garrafa) begin nph = P_FILL; take = 1'b1; end
        P_FILL: begin
          m_fill++;
          if (cheia) nph = P_CHECK;
          else if (!garrafa || m_fill >= FILL_TIMEOUT) nph = P_FAULT;
        end
        P_CHECK: if (reprovado) begin
                   nph = P_DISC;
                   if (m_rej < REJ_MAX) m_rej++;
                 end else if (aprovado) begin
                   nph = P_ADV;
                   m_appr++;
                 end
        P_DISC:  nph = P_ADV;
        P_ADV:   if (!garrafa) nph = P_IDLE;
        P_FAULT: if (start_pulse) nph = P_IDLE;
        default: nph = P_IDLE;
      endcase
      if (m_ph == P_FAULT || nph == P_FAULT) m_run = 0;
      else if (start_pulse) m_run = (m_run == 0) ? 1 : 0;
      if (take) m_stock--;
      if (add_pulse) m_stock = (m_stock + 1 > STOCK_MAX) ? STOCK_MAX : m_stock + 1;
      if (nph == P_FILL && m_ph != P_FILL) m_fill = 0;
      m_ph = nph;
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      chk("m.running",        int'(running),        m_run);
      chk("m.motor",          int'(motor),          int'(m_ph == P_FEED || m_ph == P_ADV));
      chk("m.valvula",        int'(valvula),        int'(m_ph == P_FILL));
      chk("m.descartado",     int'(descartado),     int'(m_ph == P_DISC));
      chk("m.alarme_timeout", int'(alarme_timeout), int'(m_ph == P_FAULT));
      chk("m.alarme_estoque", int'(alarme_estoque),
          int'(m_ph == P_IDLE && m_run != 0 && m_stock == 0));
      chk("m.estoque",        int'(estoque),        m_stock);
      chk("m.lote_parcial",   int'(lote_parcial),   m_appr % BATCH);
      chk("m.lotes",          int'(lotes),          (m_appr / BATCH) % LOTES_MOD);
      chk("m.rejeitados",     int'(rejeitados),     m_rej);
    end
  end

  task automatic cyc(input bit g, input bit c, input bit a, input bit s,
                     input bit ap, input bit rp);
    garrafa = g; cheia = c; add_pulse = a; start_pulse = s;
    aprovado = ap; reprovado = rp;
    @(negedge CLK);
    add_pulse = 1'b0; start_pulse = 1'b0; aprovado = 1'b0; reprovado = 1'b0;
  endtask

  // One bottle starting in FEED, ending one cycle after returning to IDLE.
  task automatic bottle(input bit ap, input bit rp, input bit a);
    cyc(1, 0, a, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, ap, rp);
    if (rp) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  bit g_r;

  initial begin
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    chk("rst.running", int'(running), 0);
    chk("rst.estoque", int'(estoque), 0);
    chk("rst.motor",   int'(motor),   0);
    reset = 1'b1;

    repeat (3) cyc(0, 0, 1, 0, 0, 0);
    chk("add3.estoque", int'(estoque), 3);
    cyc(0, 0, 0, 1, 0, 0);
    chk("start.running", int'(running), 1);
    chk("start.motor",   int'(motor),   0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("feed.motor",    int'(motor),   1);

    repeat (3) bottle(1, 0, 0);
    chk("empty.alarme", int'(alarme_estoque), 1);
    chk("empty.motor",  int'(motor),          0);
    chk("empty.lote_parcial", int'(lote_parcial), 3);
    cyc(0, 0, 1, 0, 0, 0);
    chk("refill.estoque", int'(estoque), 1);
    chk("refill.alarme",  int'(alarme_estoque), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("refill.motor", int'(motor), 1);

    repeat (11) cyc(0, 0, 1, 0, 0, 0);
    chk("stock12", int'(estoque), 12);
    repeat (12) bottle(1, 0, 0);
    chk("batch.lotes",        int'(lotes),        1);
    chk("batch.lote_parcial", int'(lote_parcial), 3);
    chk("batch.estoque",      int'(estoque),      0);

    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    chk("rej.descartado",   int'(descartado),   1);
    chk("rej.rejeitados",   int'(rejeitados),   1);
    chk("rej.lote_parcial", int'(lote_parcial), 3);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rej.descartado_off", int'(descartado), 0);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (49) cyc(1, 0, 0, 0, 0, 0);
    chk("tmo.valvula_49", int'(valvula), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("tmo.valvula",  int'(valvula),        0);
    chk("tmo.alarme",   int'(alarme_timeout), 1);
    chk("tmo.running",  int'(running),        0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("clr.alarme",   int'(alarme_timeout), 0);
    chk("clr.running",  int'(running),        0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("clr.motor",    int'(motor),          0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("restart.running", int'(running), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("restart.motor",   int'(motor),   1);

    cyc(1, 0, 0, 0, 0, 0);
    chk("midfill.valvula", int'(valvula), 1);
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("mrst.valvula", int'(valvula), 0);
    chk("mrst.running", int'(running), 0);
    chk("mrst.lotes",   int'(lotes),   0);
    chk("mrst.rejeitados", int'(rejeitados), 0);
    reset = 1'b1;

    repeat (100) cyc(0, 0, 1, 0, 0, 0);
    chk("sat.estoque", int'(estoque), 99);
    cyc(0, 0, 1, 0, 0, 0);
    chk("sat.hold", int'(estoque), 99);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("addtake.estoque", int'(estoque), 99);
    chk("addtake.valvula", int'(valvula), 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    repeat (260) bottle(0, 1, 1);
    chk("rejsat.rejeitados", int'(rejeitados), 255);
    chk("rejsat.estoque",    int'(estoque),    99);

    g_r = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) g_r = !g_r;
      reset = ($urandom_range(0, 599) != 0);
      cyc(g_r, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
